// File: rtl/trigger_pkg.sv
// Shared constants and the per-bit next-state decision type for the trigger bank.
package trigger_pkg;

    localparam int BOTH_HOLD   = 0;
    localparam int BOTH_TOGGLE = 1;
    localparam int BOTH_RESET  = 2;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2,
        TOG  = 2'd3
    } trig_action_t;

    // Action taken when a gated AC set and a gated AC reset land on one bit together.
    function automatic trig_action_t both_action(input int mode);
        case (mode)
            BOTH_TOGGLE: return TOG;
            BOTH_RESET:  return CLR;
            default:     return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/trigger_cell.sv
// One trigger bit: DC levels override gated AC events; registered DC conflict flag.
// Optional registered AC-change pulse when TRIGGER_BANK_EVENT_EN is defined.
module trigger_cell
    import trigger_pkg::*;
#(
    parameter logic INIT_BIT  = 1'b0,
    parameter int   BOTH_MODE = BOTH_TOGGLE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_gs,
    input  logic i_gr,
    input  logic i_dc_set_n,
    input  logic i_dc_reset_n,
`ifdef TRIGGER_BANK_EVENT_EN
    output logic o_event,
`endif
    output logic o_state,
    output logic o_nout,
    output logic o_conflict
);

    trig_action_t action;
    logic         state_d;
    logic         conflict_d;
    logic         dc_active;

    always_comb begin
        action     = HOLD;
        conflict_d = 1'b0;
        dc_active  = 1'b0;
        if (!i_dc_reset_n && !i_dc_set_n) begin
            action     = CLR;
            conflict_d = 1'b1;
            dc_active  = 1'b1;
        end else if (!i_dc_reset_n) begin
            action    = CLR;
            dc_active = 1'b1;
        end else if (!i_dc_set_n) begin
            action    = SET;
            dc_active = 1'b1;
        end else if (i_gs && i_gr) begin
            action = both_action(BOTH_MODE);
        end else if (i_gs) begin
            action = SET;
        end else if (i_gr) begin
            action = CLR;
        end
    end

    always_comb begin
        state_d = o_state;
        case (action)
            SET:     state_d = 1'b1;
            CLR:     state_d = 1'b0;
            TOG:     state_d = ~o_state;
            default: state_d = o_state;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state    <= INIT_BIT;
            o_conflict <= 1'b0;
        end else begin
            o_state    <= state_d;
            o_conflict <= conflict_d;
        end
    end

    // Both transistor halves are forced off while the DC inputs fight.
    assign o_nout = o_conflict ? 1'b0 : ~o_state;

`ifdef TRIGGER_BANK_EVENT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_event <= 1'b0;
        end else begin
            o_event <= !dc_active && (state_d != o_state);
        end
    end
`else
    logic unused_dc_active;
    assign unused_dc_active = dc_active;
`endif

endmodule

// File: rtl/trigger_bank.sv
// W-bit bank of SLT-style triggers sharing edge-detected AC set/reset lines.
// Define TRIGGER_BANK_EVENT_EN to add the registered o_event output.
module trigger_bank
    import trigger_pkg::*;
#(
    parameter int           W         = 4,
    parameter logic [W-1:0] INIT      = '0,
    parameter bit           AC_RISING = 1'b1,
    parameter int           BOTH_MODE = BOTH_TOGGLE
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_set_gate,
    input  logic [W-1:0] i_reset_gate,
    input  logic         i_ac_set,
    input  logic         i_ac_reset,
    input  logic [W-1:0] i_dc_set_n,
    input  logic [W-1:0] i_dc_reset_n,
`ifdef TRIGGER_BANK_EVENT_EN
    output logic [W-1:0] o_event,
`endif
    output logic [W-1:0] o_out,
    output logic [W-1:0] o_nout,
    output logic [W-1:0] o_conflict
);

    // Idle level of the AC lines; the history resets here so release never fakes an edge.
    localparam logic IDLE = AC_RISING ? 1'b0 : 1'b1;

    logic ac_set_q;
    logic ac_reset_q;
    logic set_ev;
    logic reset_ev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ac_set_q   <= IDLE;
            ac_reset_q <= IDLE;
        end else begin
            ac_set_q   <= i_ac_set;
            ac_reset_q <= i_ac_reset;
        end
    end

    assign set_ev   = AC_RISING ? (i_ac_set & ~ac_set_q)     : (~i_ac_set & ac_set_q);
    assign reset_ev = AC_RISING ? (i_ac_reset & ~ac_reset_q) : (~i_ac_reset & ac_reset_q);

    for (genvar b = 0; b < W; b++) begin : g_cell
        trigger_cell #(
            .INIT_BIT  (INIT[b]),
            .BOTH_MODE (BOTH_MODE)
        ) u_cell (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_gs         (set_ev & i_set_gate[b]),
            .i_gr         (reset_ev & i_reset_gate[b]),
            .i_dc_set_n   (i_dc_set_n[b]),
            .i_dc_reset_n (i_dc_reset_n[b]),
`ifdef TRIGGER_BANK_EVENT_EN
            .o_event      (o_event[b]),
`endif
            .o_state      (o_out[b]),
            .o_nout       (o_nout[b]),
            .o_conflict   (o_conflict[b])
        );
    end

endmodule

// File: tb/tb_trigger_bank.sv
// Directed bench: three rising-edge banks differing only in BOTH_MODE share stimulus;
// a fourth bank exercises falling-edge AC detection.
module tb_trigger_bank;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Shared stimulus for the rising-edge banks
    logic [W-1:0] set_gate, reset_gate, dc_set_n, dc_reset_n;
    logic         ac_set, ac_reset;
    logic [W-1:0] out1, nout1, conf1, out0, nout0, conf0, out2, nout2, conf2;

    // Falling-edge bank
    logic [W-1:0] f_set_gate, f_reset_gate, f_dc_set_n, f_dc_reset_n;
    logic         f_ac_set, f_ac_reset;
    logic [W-1:0] f_out, f_nout, f_conf;

`ifdef TRIGGER_BANK_EVENT_EN
    logic [W-1:0] ev1, ev0, ev2, f_ev;
`endif

    int checks = 0;
    int errors = 0;

    trigger_bank #(.W(W), .INIT(4'b1010), .AC_RISING(1'b1), .BOTH_MODE(1)) dut_tog (
        .i_clk(clk), .i_rst_n(rst_n), .i_set_gate(set_gate), .i_reset_gate(reset_gate),
        .i_ac_set(ac_set), .i_ac_reset(ac_reset), .i_dc_set_n(dc_set_n), .i_dc_reset_n(dc_reset_n),
`ifdef TRIGGER_BANK_EVENT_EN
        .o_event(ev1),
`endif
        .o_out(out1), .o_nout(nout1), .o_conflict(conf1));

    trigger_bank #(.W(W), .INIT(4'b1010), .AC_RISING(1'b1), .BOTH_MODE(0)) dut_hold (
        .i_clk(clk), .i_rst_n(rst_n), .i_set_gate(set_gate), .i_reset_gate(reset_gate),
        .i_ac_set(ac_set), .i_ac_reset(ac_reset), .i_dc_set_n(dc_set_n), .i_dc_reset_n(dc_reset_n),
`ifdef TRIGGER_BANK_EVENT_EN
        .o_event(ev0),
`endif
        .o_out(out0), .o_nout(nout0), .o_conflict(conf0));

    trigger_bank #(.W(W), .INIT(4'b1010), .AC_RISING(1'b1), .BOTH_MODE(2)) dut_rst (
        .i_clk(clk), .i_rst_n(rst_n), .i_set_gate(set_gate), .i_reset_gate(reset_gate),
        .i_ac_set(ac_set), .i_ac_reset(ac_reset), .i_dc_set_n(dc_set_n), .i_dc_reset_n(dc_reset_n),
`ifdef TRIGGER_BANK_EVENT_EN
        .o_event(ev2),
`endif
        .o_out(out2), .o_nout(nout2), .o_conflict(conf2));

    trigger_bank #(.W(W), .INIT(4'b0000), .AC_RISING(1'b0), .BOTH_MODE(1)) dut_fall (
        .i_clk(clk), .i_rst_n(rst_n), .i_set_gate(f_set_gate), .i_reset_gate(f_reset_gate),
        .i_ac_set(f_ac_set), .i_ac_reset(f_ac_reset), .i_dc_set_n(f_dc_set_n), .i_dc_reset_n(f_dc_reset_n),
`ifdef TRIGGER_BANK_EVENT_EN
        .o_event(f_ev),
`endif
        .o_out(f_out), .o_nout(f_nout), .o_conflict(f_conf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs[W-1:0], exp[W-1:0]);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        set_gate = '0; reset_gate = '0; dc_set_n = '1; dc_reset_n = '1;
        ac_set = 1'b0; ac_reset = 1'b0;
        f_set_gate = '0; f_reset_gate = '0; f_dc_set_n = '1; f_dc_reset_n = '1;
        f_ac_set = 1'b1; f_ac_reset = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", out1, 4'b1010);
        check("rst_nout", nout1, 4'b0101);
        check("rst_conf", conf1, 4'b0000);
        check("rst_fall_out", f_out, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("release_idle", out1, 4'b1010);
        check("release_idle_fall", f_out, 4'b0000);

        // AC set
        set_gate = 4'b0011;
        ac_set = 1'b1;
        tick();
        check("ac_set", out1, 4'b1011);
        tick(5);
        check("ac_set_held", out1, 4'b1011);
        set_gate = 4'b1111;
        tick();
        check("gate_no_event", out1, 4'b1011);

        // AC reset
        reset_gate = 4'b1000;
        ac_reset = 1'b1;
        tick();
        check("ac_reset", out1, 4'b0011);
        ac_reset = 1'b0;
        tick();
        check("ac_reset_fall", out1, 4'b0011);
        reset_gate = 4'b0000;
        ac_reset = 1'b1;
        tick();
        check("ac_reset_ungated", out1, 4'b0011);

        // Simultaneous set/reset on bit0 with state=1
        ac_set = 1'b0; ac_reset = 1'b0;
        tick();
        set_gate = 4'b0001; reset_gate = 4'b0001;
        ac_set = 1'b1; ac_reset = 1'b1;
        tick();
        check("both_toggle", out1, 4'b0010);
        check("both_hold", out0, 4'b0011);
        check("both_reset", out2, 4'b0010);

        // Mid-operation reset with AC set held active, then one event on release
        reset_gate = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", out0, 4'b1010);
        check("midrst_out_tog", out1, 4'b1010);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("release_active_ac", out1, 4'b1011);
        tick();
        check("release_one_event", out1, 4'b1011);

        // DC priority over AC and DC conflict
        ac_set = 1'b0; ac_reset = 1'b0;
        tick();
        dc_set_n = 4'b1110;
        reset_gate = 4'b0001;
        ac_reset = 1'b1;
        tick();
        check("dc_set_over_ac", out1, 4'b1011);
        check("dc_set_noconf", conf1, 4'b0000);
        dc_reset_n = 4'b1110;
        tick();
        check("conf_out", out1, 4'b1010);
        check("conf_nout", nout1, 4'b0100);
        check("conf_flag", conf1, 4'b0001);
        dc_set_n = 4'b1111; dc_reset_n = 4'b1111;
        tick();
        check("conf_clear", conf1, 4'b0000);
        check("conf_hold", out1, 4'b1010);
        check("conf_clear_nout", nout1, 4'b0101);
        dc_reset_n = 4'b0111;
        tick();
        check("dc_reset", out1, 4'b0010);
        dc_reset_n = 4'b1111;

        // Falling-edge bank
        f_set_gate = 4'b0001;
        f_ac_set = 1'b0;
        tick();
        check("fall_set", f_out, 4'b0001);
`ifdef TRIGGER_BANK_EVENT_EN
        check("fall_event", f_ev, 4'b0001);
`endif
        tick();
`ifdef TRIGGER_BANK_EVENT_EN
        check("fall_event_pulse", f_ev, 4'b0000);
`endif
        f_ac_set = 1'b1;
        tick();
        check("fall_rising_noev", f_out, 4'b0001);
        f_ac_set = 1'b0;
        tick();
        check("fall_set_again", f_out, 4'b0001);
`ifdef TRIGGER_BANK_EVENT_EN
        check("fall_event_nochg", f_ev, 4'b0000);
`endif
        f_reset_gate = 4'b0001;
        f_ac_reset = 1'b0;
        tick();
        check("fall_reset", f_out, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_bank.md
Name: trigger_bank

Overview:
- W-bit bank of SLT-style triggers for the x2821 logic emulation; the parametrised successor to the single trigger.
- Each bit has per-bit set/reset gates and per-bit active-low DC set/reset.
- Bits share one AC set line and one AC reset line, which are edge-detected inside the block.
- Adds selectable edge polarity, configurable simultaneous-set/reset handling (hold / toggle / reset-wins), a conflict flag and a reset init value.

Parameters:
- W, 4, number of trigger bits.
- INIT, 0 (W bits), o_out value loaded by reset.
- AC_RISING, 1, 1 = AC event on 0->1 of the AC line; 0 = AC event on 1->0.
- BOTH_MODE, 1, action when gated AC set and gated AC reset coincide on one bit: 0 = hold, 1 = toggle, 2 = reset wins.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_set_gate  in  W  per-bit enable for AC set
- i_reset_gate  in  W  per-bit enable for AC reset
- i_ac_set  in  1  shared AC set line (edge-sensitive)
- i_ac_reset  in  1  shared AC reset line (edge-sensitive)
- i_dc_set_n  in  W  per-bit DC set, active low, level
- i_dc_reset_n  in  W  per-bit DC reset, active low, level
- o_out  out  W  trigger state
- o_nout  out  W  complement output (see Behaviour)
- o_conflict  out  W  registered; 1 when both DC inputs of that bit were low last cycle

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - state = INIT; o_nout = ~INIT; o_conflict = 0.
  - ac_set_q = ac_reset_q = idle level (0 if AC_RISING, else 1), so no spurious event at reset release.
- Edge detect, per AC line:
  - ac_q registers the line every clock.
  - set_ev = (AC_RISING ? i_ac_set & ~ac_set_q : ~i_ac_set & ac_set_q); reset_ev likewise.
  - The event is true for exactly one cycle per line transition; a held line gives no further events.
- Gating: gs[b] = set_ev & i_set_gate[b]; gr[b] = reset_ev & i_reset_gate[b]. Gates are sampled in the same cycle as the event; gate changes with no event have no effect.
- Next-state priority per bit, highest first, evaluated at each rising i_clk:
  1. dc_reset_n = 0 and dc_set_n = 0 -> state 0, conflict 1.
  2. dc_reset_n = 0 -> 0.
  3. dc_set_n = 0 -> 1.
  4. gs & gr -> BOTH_MODE action (hold / ~state / 0).
  5. gs -> 1.
  6. gr -> 0.
  7. otherwise hold.
- DC inputs are synchronous levels; they override AC events in the same cycle and hold the bit while active.
- Latency: o_out reflects a change at the same clock edge that first samples the AC transition or DC level. There is no extra pipeline stage.
- o_nout = ~o_out, except it is 0 for any bit in DC conflict. This models both transistor halves being forced off.
- Bits are independent; one AC event updates every gated bit in the same cycle.
- Reset asserted mid-operation: immediate return to INIT. Pending edge history is discarded (ac_q forced to idle).
- AC line already active at reset release: ac_q is idle, so one event fires on the first clock after release.

Optional Feature:
- TRIGGER_BANK_EVENT_EN defined:
  - adds output o_event [W], registered.
  - o_event[b] pulses 1 for one cycle when the bit's state changed because of an AC event (priorities 4-6).
  - DC-caused changes and reset do not pulse; reset value 0.
- Not defined: port absent, no event logic.

Decomposition:
- Package trigger_pkg:
  - BOTH_HOLD = 0, BOTH_TOGGLE = 1, BOTH_RESET = 2.
  - Typedef trig_action_t (HOLD, SET, CLR, TOG) for the next-state decision.
- Sub-module trigger_cell: one bit. Inputs are gs, gr, dc_set_n, dc_reset_n; outputs are state, nout and conflict.
- Edge detectors stay in trigger_bank, shared by all cells; trigger_bank instantiates W cells with a generate loop.

Test Plan:
- Reset with W=4, INIT=4'b1010: hold i_rst_n=0 -> o_out=1010, o_nout=0101, o_conflict=0; release with AC idle -> no change.
- AC set: set_gate=0011, DC inactive (1111); raise i_ac_set -> o_out=1011 on the next edge. Hold i_ac_set high 5 cycles -> no further change. Set_gate=1111 while the line is held -> still 1011.
- AC reset: reset_gate=1000, raise i_ac_reset -> o_out=0011. Drop and re-raise with reset_gate=0000 -> unchanged.
- Simultaneous gated set and reset on bit0, state=1, both lines rising in the same cycle:
  - BOTH_MODE=1 -> bit0 becomes 0.
  - BOTH_MODE=0 -> stays 1.
  - BOTH_MODE=2 -> 0.
- DC priority and conflict: dc_set_n=1110 with a gated AC reset on bit0 in the same cycle -> bit0=1. Then dc_reset_n=1110 with dc_set_n=1110 -> bit0 o_out=0, o_nout=0, o_conflict=1 next cycle; release both -> conflict clears, bit0 holds 0.
- AC_RISING=0 with TRIGGER_BANK_EVENT_EN: falling i_ac_set with set_gate=0001 and bit0=0 -> o_out bit0=1 and a one-cycle o_event=0001. Same stimulus with bit0 already 1 -> o_event=0000.
